mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 107 ++++++++++
 tb/tb_mem_copy_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-by-word copy engine driving a single-port 16-bit RAM.
// Each word is read, captured, then written (3 cycles per word).
module mem_copy_engine #(
    parameter int SIZE  = 13,
    parameter int DEPTH = 8192
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_src,
    input  logic [SIZE-1:0] i_dst,
    input  logic [SIZE-1:0] i_len,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_ram_we,
    output logic [SIZE-1:0] o_ram_addr,
    output logic [15:0]     o_ram_wdata,
    input  logic [15:0]     i_ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam logic [SIZE-1:0] AMASK = SIZE'(DEPTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [SIZE-1:0] src;
    logic [SIZE-1:0] dst;
    logic [SIZE-1:0] len;
    logic [SIZE-1:0] k;
    logic [15:0]     data;
    logic            last;

    // Widened compare so k+1 cannot overflow at the top of the range
    assign last = ({1'b0, k} + (SIZE+1)'(1)) >= {1'b0, len};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            k     <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_start && (i_len != '0)) begin
                        src <= i_src;
                        dst <= i_dst;
                        len <= i_len;
                        k   <= '0;
                    end
                end
                CAP:     data <= i_ram_rdata;
                WR:      k    <= k + SIZE'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = (i_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                o_busy     = 1'b1;
                o_ram_addr = (src + k) & AMASK;
                state_nxt  = CAP;
            end
            CAP: begin
                o_busy     = 1'b1;
                o_ram_addr = (src + k) & AMASK;
                state_nxt  = WR;
            end
            WR: begin
                o_busy      = 1'b1;
                o_ram_we    = 1'b1;
                o_ram_addr  = (dst + k) & AMASK;
                o_ram_wdata = data;
                state_nxt   = last ? DONE : RD;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural RAM.
// Table-driven copies plus directed reset / restart / wrap sequences.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [12:0] i_src = '0;
    logic [12:0] i_dst = '0;
    logic [12:0] i_len = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_ram_we;
    logic [12:0] o_ram_addr;
    logic [15:0] o_ram_wdata;
    logic [15:0] i_ram_rdata;

    mem_copy_engine #(.SIZE(13), .DEPTH(8192)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_src       (i_src),
        .i_dst       (i_dst),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:8191];
    logic [15:0] model [0:8191];
    logic        ram_init = 1'b0;
    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 16'h1000 + i[15:0];
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
        end
        i_ram_rdata <= mem[o_ram_addr];
    end

    // Activity monitor, cleared by the bench at each copy start
    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          busy_cnt;
    int          done_cnt;
    int          we_cnt;
    int          done_cyc;
    int          last_we_cyc;
    logic [12:0] wa [0:15];
    logic [15:0] wd [0:15];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            busy_cnt <= 0;
            done_cnt <= 0;
            we_cnt   <= 0;
        end else begin
            if (o_busy) busy_cnt <= busy_cnt + 1;
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (o_ram_we) begin
                we_cnt      <= we_cnt + 1;
                last_we_cyc <= cyc;
                if (we_cnt < 16) begin
                    wa[we_cnt] <= o_ram_addr;
                    wd[we_cnt] <= o_ram_wdata;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_copy(input logic [12:0] s, input logic [12:0] d,
                              input logic [12:0] n);
        @(negedge clk);
        i_start = 1'b1;
        i_src   = s;
        i_dst   = d;
        i_len   = n;
        mon_clr = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        mon_clr = 1'b0;
        i_src   = ~s;
        i_dst   = ~d;
        i_len   = n + 13'd2;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && done_cnt == 0; n++) @(negedge clk);
        if (done_cnt == 0) begin
            failures++;
            checks++;
            $display("FAIL timeout: no done within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [12:0] src;
        logic [12:0] dst;
        logic [12:0] len;
        int          exp_busy;
        int          exp_we;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        logic [15:0] e;
        logic [12:0] a;

        vecs[0] = '{13'h0010, 13'h0100, 13'd4, 12, 4};
        vecs[1] = '{13'h0005, 13'h0009, 13'd0, 0, 0};
        vecs[2] = '{13'h0020, 13'h0021, 13'd3, 9, 3};
        vecs[3] = '{13'h1FFD, 13'h0300, 13'd5, 15, 5};
        vecs[4] = '{13'h0400, 13'h0200, 13'd1, 3, 1};
        for (int i = 0; i < 8192; i++) model[i] = 16'h1000 + i[15:0];

        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_we", {31'd0, o_ram_we}, 32'd0);
        chk("rst_addr", {19'd0, o_ram_addr}, 32'd0);
        chk("rst_wdata", {16'd0, o_ram_wdata}, 32'd0);

        @(negedge clk);
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            start_copy(vecs[v].src, vecs[v].dst, vecs[v].len);
            wait_done(3 * int'(vecs[v].len) + 8);
            chk($sformatf("v%0d_busy", v), busy_cnt, vecs[v].exp_busy);
            chk($sformatf("v%0d_we", v), we_cnt, vecs[v].exp_we);
            chk($sformatf("v%0d_done", v), done_cnt, 1);
            if (vecs[v].len != 0)
                chk($sformatf("v%0d_lat", v), done_cyc, last_we_cyc + 1);
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                e = model[vecs[v].src + 13'(k)];
                a = vecs[v].dst + 13'(k);
                model[a] = e;
                chk($sformatf("v%0d_wa%0d", v, k), {19'd0, wa[k]}, {19'd0, a});
                chk($sformatf("v%0d_wd%0d", v, k), {16'd0, wd[k]}, {16'd0, e});
                chk($sformatf("v%0d_mem%0d", v, k), {16'd0, mem[a]},
                    {16'd0, e});
            end
        end

        // zero-length: done on the cycle right after acceptance
        start_copy(13'd5, 13'd9, 13'd0);
        chk("len0_done_now", {31'd0, o_done}, 32'd1);
        chk("len0_busy_now", {31'd0, o_busy}, 32'd0);
        wait_done(6);
        chk("len0_we", we_cnt, 0);
        chk("len0_busy", busy_cnt, 0);

        // wraparound with overlapping destination
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = 13'h1FFE; pre_data = 16'hAAAA;
        @(negedge clk);
        pre_addr = 13'h1FFF; pre_data = 16'hBBBB;
        @(negedge clk);
        pre_addr = 13'h0000; pre_data = 16'hCCCC;
        @(negedge clk);
        pre_we = 1'b0;
        start_copy(13'h1FFE, 13'h0000, 13'd3);
        wait_done(20);
        chk("wrap_we", we_cnt, 3);
        chk("wrap_a0", {19'd0, wa[0]}, 32'h0);
        chk("wrap_a1", {19'd0, wa[1]}, 32'h1);
        chk("wrap_a2", {19'd0, wa[2]}, 32'h2);
        chk("wrap_d0", {16'd0, wd[0]}, 32'hAAAA);
        chk("wrap_d1", {16'd0, wd[1]}, 32'hBBBB);
        chk("wrap_d2", {16'd0, wd[2]}, 32'hAAAA);
        model[0] = 16'hAAAA; model[1] = 16'hBBBB; model[2] = 16'hAAAA;
        model[13'h1FFE] = 16'hAAAA; model[13'h1FFF] = 16'hBBBB;

        // restart request during word 1 must be ignored
        start_copy(13'h0040, 13'h0080, 13'd3);
        repeat (3) @(negedge clk);
        i_start = 1'b1;
        i_src = 13'h0700; i_dst = 13'h0600; i_len = 13'd7;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(30);
        chk("rstart_we", we_cnt, 3);
        chk("rstart_busy", busy_cnt, 9);
        chk("rstart_done", done_cnt, 1);
        chk("rstart_a2", {19'd0, wa[2]}, 32'h82);
        chk("rstart_d2", {16'd0, wd[2]}, {16'd0, model[13'h42]});
        for (int k = 0; k < 3; k++) model[13'h80 + k] = model[13'h40 + k];

        // reset during CAP of word 2 of a 5-word copy
        start_copy(13'h0050, 13'h0090, 13'd5);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_we", {31'd0, o_ram_we}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_addr", {19'd0, o_ram_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model[13'h90] = model[13'h50];
        model[13'h91] = model[13'h51];
        chk("abort_wcnt", we_cnt, 2);
        chk("abort_done", done_cnt, 0);
        chk("abort_m0", {16'd0, mem[13'h90]}, {16'd0, model[13'h90]});
        chk("abort_m1", {16'd0, mem[13'h91]}, {16'd0, model[13'h91]});
        chk("abort_m2", {16'd0, mem[13'h92]}, {16'd0, model[13'h92]});

        start_copy(13'h0123, 13'h0456, 13'd1);
        wait_done(10);
        chk("post_busy", busy_cnt, 3);
        chk("post_done", done_cnt, 1);
        chk("post_mem", {16'd0, mem[13'h456]}, {16'd0, model[13'h123]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
